// File: rtl/med_pkg.sv
// med_pkg: shared types and constants for the medication scheduler.
package med_pkg;

  // Scheduler FSM states; SNOOZE is only reachable in MED_SNOOZE_EN builds.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALARM  = 2'd1,
    SNOOZE = 2'd2
  } med_state_e;

  // Snoozes allowed per dose; the next snooze request counts as a miss.
  localparam int SNOOZE_MAX = 3;

  // Log entry layout at the default geometry (TIME_W=8, N_SLOTS=16).
  localparam int MED_TIME_W = 8;
  localparam int MED_SLOT_W = 4;

  typedef struct packed {
    logic [MED_TIME_W-1:0] due_time;
    logic [MED_SLOT_W-1:0] idx;
    logic                  taken;
  } med_log_t;

  // Width of a packed log entry {due_time, idx, taken}.
  function automatic int log_width(input int time_w, input int slot_w);
    return time_w + slot_w + 1;
  endfunction

endpackage

// File: rtl/med_log_fifo.sv
// med_log_fifo: first-word-fall-through FIFO. A write into a full FIFO
// without a read drops the oldest entry and sets a sticky overflow flag.
module med_log_fifo
#(
  parameter int  WIDTH = 13,
  parameter int  DEPTH = 16,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             full_s, do_rd_s, drop_s;

  // Next-state for storage, pointers, occupancy and the overflow flag.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    full_s   = (cnt_q == (PTR_W+1)'(DEPTH));
    do_rd_s  = rd_en && (cnt_q != {(PTR_W+1){1'b0}});
    drop_s   = wr_en && full_s && !do_rd_s;

    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // A pop and an overwrite both retire the head entry.
    if (do_rd_s || drop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en, do_rd_s})
      2'b10: begin
        if (full_s) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + (PTR_W+1)'(1);
        end
      end
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase

    if (clr_ovf) begin
      ovf_d = 1'b0;
    end else if (drop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      cnt_q    <= {(PTR_W+1){1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (cnt_q == {(PTR_W+1){1'b0}});
  assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
  assign ovf     = ovf_q;

endmodule

// File: rtl/med_sched_ctrl.sv
// med_sched_ctrl: medication scheduler with programmable dose slots, a
// wrapping day clock, an ack/timeout alarm and a taken/missed event log.
// Optional feature macro: MED_SNOOZE_EN (adds the SNOOZE state).
module med_sched_ctrl
  import med_pkg::*;
#(
  parameter int  N_SLOTS      = 16,
  parameter int  TIME_W       = 8,
  parameter int  TICK_DIV     = 1,
  parameter int  LOG_DEPTH    = 16,
  parameter int  ACK_TIMEOUT  = 32,
  parameter int  SNOOZE_TICKS = 8,
  localparam int SLOT_W       = $clog2(N_SLOTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [TIME_W-1:0] prog_time,
  input  logic              clear,
  input  logic              ack,
  input  logic              snooze,
  output logic              alarm,
  output logic [SLOT_W-1:0] alarm_idx,
  output logic              missed,
  output logic [TIME_W-1:0] now,
  output logic [SLOT_W:0]   slot_count,
  input  logic              log_rd,
  output logic              log_empty,
  output logic              log_full,
  output logic              log_ovf,
  output logic [TIME_W-1:0] log_time,
  output logic [SLOT_W-1:0] log_idx,
  output logic              log_taken
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam int LOG_W = log_width(TIME_W, SLOT_W);

  typedef struct packed {
    logic [TIME_W-1:0] due_time;
    logic [SLOT_W-1:0] idx;
    logic              taken;
  } log_entry_t;

  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick_s;
  logic [TIME_W-1:0]  now_q, now_d;
  logic               ack_prev_q, ack_edge_s;
  logic [TIME_W-1:0]  slot_time_q [N_SLOTS];
  logic [TIME_W-1:0]  slot_time_d [N_SLOTS];
  logic [N_SLOTS-1:0] slot_valid_q, slot_valid_d;
  logic [SLOT_W:0]    slot_count_q, slot_count_d;
  logic               prog_ready_s;
  logic [N_SLOTS-1:0] match_s, pick_mask_s, pending_q, pending_d;
  logic [SLOT_W-1:0]  pick_idx_s;
  med_state_e         state_q, state_d;
  logic               alarm_q, alarm_d, missed_q, missed_d;
  logic [SLOT_W-1:0]  alarm_idx_q, alarm_idx_d;
  logic [TIME_W-1:0]  due_q, due_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               log_wr_s, log_taken_s;
  log_entry_t         log_wr_data_s, log_head_s;
  logic [LOG_W-1:0]   log_rd_data_s;

`ifdef MED_SNOOZE_EN
  localparam int SNZ_W = $clog2(SNOOZE_TICKS + 1);
  logic [1:0]       snz_cnt_q, snz_cnt_d;
  logic [SNZ_W-1:0] snz_tick_q, snz_tick_d;
`else
  logic [32:0] unused_snooze_s;
  assign unused_snooze_s = {snooze, 32'(SNOOZE_TICKS)};
`endif

  assign ack_edge_s   = ack & ~ack_prev_q;
  assign prog_ready_s = (slot_count_q < (SLOT_W+1)'(N_SLOTS));

  // Prescaler and day clock; the match logic sees the pre-increment time.
  always_comb begin
    tick_s = (div_q == DIV_W'(TICK_DIV - 1));
    if (tick_s) begin
      div_d = {DIV_W{1'b0}};
      now_d = now_q + TIME_W'(1);
    end else begin
      div_d = div_q + DIV_W'(1);
      now_d = now_q;
    end
  end

  // Slot table writes; clear outranks a simultaneous program request.
  always_comb begin
    slot_time_d  = slot_time_q;
    slot_valid_d = slot_valid_q;
    slot_count_d = slot_count_q;
    if (clear) begin
      slot_valid_d = {N_SLOTS{1'b0}};
      slot_count_d = {(SLOT_W+1){1'b0}};
    end else if (prog_valid && prog_ready_s) begin
      slot_time_d[slot_count_q[SLOT_W-1:0]]  = prog_time;
      slot_valid_d[slot_count_q[SLOT_W-1:0]] = 1'b1;
      slot_count_d = slot_count_q + (SLOT_W+1)'(1);
    end else begin
      slot_count_d = slot_count_q;
    end
  end

  // Tick matches per slot, and the lowest pending slot with its one-hot mask.
  always_comb begin
    pick_idx_s = {SLOT_W{1'b0}};
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      pick_idx_s = pending_q[i] ? SLOT_W'(i) : pick_idx_s;
    end
    for (int i = 0; i < N_SLOTS; i++) begin
      pick_mask_s[i] = (SLOT_W'(i) == pick_idx_s);
      match_s[i]     = tick_s && slot_valid_q[i] && (slot_time_q[i] == now_q);
    end
  end

  // Alarm FSM next state: pick a dose, then resolve it by ack, timeout or snooze.
  always_comb begin
    state_d     = state_q;
    alarm_d     = alarm_q;
    alarm_idx_d = alarm_idx_q;
    due_d       = due_q;
    tmo_d       = tmo_q;
    missed_d    = 1'b0;
    pending_d   = pending_q | match_s;
    log_wr_s    = 1'b0;
    log_taken_s = 1'b0;
`ifdef MED_SNOOZE_EN
    snz_cnt_d   = snz_cnt_q;
    snz_tick_d  = snz_tick_q;
`endif
    if (clear) begin
      state_d   = IDLE;
      alarm_d   = 1'b0;
      pending_d = {N_SLOTS{1'b0}};
      tmo_d     = {TMO_W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (pending_q != {N_SLOTS{1'b0}}) begin
            pending_d   = (pending_q & ~pick_mask_s) | match_s;
            state_d     = ALARM;
            alarm_d     = 1'b1;
            alarm_idx_d = pick_idx_s;
            due_d       = slot_time_q[pick_idx_s];
            tmo_d       = {TMO_W{1'b0}};
`ifdef MED_SNOOZE_EN
            snz_cnt_d   = 2'd0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
        ALARM: begin
          if (ack_edge_s) begin
            log_wr_s    = 1'b1;
            log_taken_s = 1'b1;
            alarm_d     = 1'b0;
            state_d     = IDLE;
          end else if (tick_s && (tmo_q == TMO_W'(ACK_TIMEOUT - 1))) begin
            log_wr_s = 1'b1;
            missed_d = 1'b1;
            alarm_d  = 1'b0;
            state_d  = IDLE;
`ifdef MED_SNOOZE_EN
          end else if (snooze && (snz_cnt_q == 2'(SNOOZE_MAX))) begin
            log_wr_s = 1'b1;
            missed_d = 1'b1;
            alarm_d  = 1'b0;
            state_d  = IDLE;
          end else if (snooze) begin
            snz_cnt_d  = snz_cnt_q + 2'd1;
            snz_tick_d = {SNZ_W{1'b0}};
            alarm_d    = 1'b0;
            state_d    = SNOOZE;
`endif
          end else if (tick_s) begin
            tmo_d = tmo_q + TMO_W'(1);
          end else begin
            tmo_d = tmo_q;
          end
        end
`ifdef MED_SNOOZE_EN
        SNOOZE: begin
          if (ack_edge_s) begin
            log_wr_s    = 1'b1;
            log_taken_s = 1'b1;
            state_d     = IDLE;
          end else if (tick_s && (snz_tick_q == SNZ_W'(SNOOZE_TICKS - 1))) begin
            state_d = ALARM;
            alarm_d = 1'b1;
            tmo_d   = {TMO_W{1'b0}};
          end else if (tick_s) begin
            snz_tick_d = snz_tick_q + SNZ_W'(1);
          end else begin
            snz_tick_d = snz_tick_q;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          alarm_d = 1'b0;
        end
      endcase
    end
  end

  // Day clock, prescaler, ack history and slot table registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q        <= {DIV_W{1'b0}};
      now_q        <= {TIME_W{1'b0}};
      ack_prev_q   <= 1'b0;
      slot_valid_q <= {N_SLOTS{1'b0}};
      slot_count_q <= {(SLOT_W+1){1'b0}};
      for (int i = 0; i < N_SLOTS; i++) begin
        slot_time_q[i] <= {TIME_W{1'b0}};
      end
    end else begin
      div_q        <= div_d;
      now_q        <= now_d;
      ack_prev_q   <= ack;
      slot_valid_q <= slot_valid_d;
      slot_count_q <= slot_count_d;
      slot_time_q  <= slot_time_d;
    end
  end

  // Alarm FSM registers, including the registered alarm/missed outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alarm_q     <= 1'b0;
      alarm_idx_q <= {SLOT_W{1'b0}};
      due_q       <= {TIME_W{1'b0}};
      tmo_q       <= {TMO_W{1'b0}};
      missed_q    <= 1'b0;
      pending_q   <= {N_SLOTS{1'b0}};
`ifdef MED_SNOOZE_EN
      snz_cnt_q   <= 2'd0;
      snz_tick_q  <= {SNZ_W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      alarm_q     <= alarm_d;
      alarm_idx_q <= alarm_idx_d;
      due_q       <= due_d;
      tmo_q       <= tmo_d;
      missed_q    <= missed_d;
      pending_q   <= pending_d;
`ifdef MED_SNOOZE_EN
      snz_cnt_q   <= snz_cnt_d;
      snz_tick_q  <= snz_tick_d;
`endif
    end
  end

  assign log_wr_data_s = {due_q, alarm_idx_q, log_taken_s};
  assign log_head_s    = log_rd_data_s;

  med_log_fifo #(
    .WIDTH (LOG_W),
    .DEPTH (LOG_DEPTH)
  ) u_log (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (log_wr_s),
    .wr_data (log_wr_data_s),
    .rd_en   (log_rd),
    .clr_ovf (clear),
    .rd_data (log_rd_data_s),
    .empty   (log_empty),
    .full    (log_full),
    .ovf     (log_ovf)
  );

  assign prog_ready = prog_ready_s;
  assign alarm      = alarm_q;
  assign alarm_idx  = alarm_idx_q;
  assign missed     = missed_q;
  assign now        = now_q;
  assign slot_count = slot_count_q;
  assign log_time   = log_head_s.due_time;
  assign log_idx    = log_head_s.idx;
  assign log_taken  = log_head_s.taken;

endmodule

// File: tb/tb_med_sched_ctrl.sv
// tb_med_sched_ctrl: directed bench for med_sched_ctrl (LOG_DEPTH=4, TICK_DIV=1).
module tb_med_sched_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       prog_valid = 1'b0;
  logic       clear = 1'b0;
  logic       ack = 1'b0;
  logic       snooze = 1'b0;
  logic       log_rd = 1'b0;
  logic [7:0] prog_time = 8'd0;
  logic       prog_ready, alarm, missed, log_empty, log_full, log_ovf, log_taken;
  logic [3:0] alarm_idx, log_idx;
  logic [7:0] now, log_time;
  logic [4:0] slot_count;

  int         total = 0;
  int         bad = 0;
  int         seen;
  logic [7:0] t, b, c, f, g;

  always #5 clk = ~clk;

  med_sched_ctrl #(.LOG_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .prog_valid(prog_valid), .prog_ready(prog_ready),
    .prog_time(prog_time), .clear(clear), .ack(ack), .snooze(snooze),
    .alarm(alarm), .alarm_idx(alarm_idx), .missed(missed), .now(now),
    .slot_count(slot_count), .log_rd(log_rd), .log_empty(log_empty),
    .log_full(log_full), .log_ovf(log_ovf), .log_time(log_time),
    .log_idx(log_idx), .log_taken(log_taken)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic prog(input logic [7:0] tm);
    prog_valid = 1'b1;
    prog_time  = tm;
    step();
    prog_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic pop();
    log_rd = 1'b1;
    step();
    log_rd = 1'b0;
  endtask

  task automatic wait_alarm(input string tag, input int maxc);
    int n = 0;
    while (alarm !== 1'b1 && n < maxc) begin
      step();
      n++;
    end
    chk(tag, 32'(alarm), 32'd1);
  endtask

  task automatic wait_now(input string tag, input logic [7:0] v);
    int n = 0;
    while (now !== v && n < 300) begin
      step();
      n++;
    end
    chk(tag, 32'(now), 32'(v));
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_now", 32'(now), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_prog_ready", 32'(prog_ready), 32'd1);
    chk("rst_log_empty", 32'(log_empty), 32'd1);
    chk("rst_misc", {24'd0, slot_count, missed, log_full, log_ovf}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: slot0=5, alarm two cycles after the matching tick, ack logs taken
    prog(8'd5);
    chk("t1_count", 32'(slot_count), 32'd1);
    wait_now("t1_now5", 8'd5);
    chk("t1_alarm_t", 32'(alarm), 32'd0);
    step();
    chk("t1_alarm_t1", 32'(alarm), 32'd0);
    step();
    chk("t1_alarm_t2", 32'(alarm), 32'd1);
    chk("t1_idx", 32'(alarm_idx), 32'd0);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t1_alarm_off", 32'(alarm), 32'd0);
    chk("t1_log", {log_empty, log_time, log_idx, log_taken}, {1'b0, 8'd5, 4'd0, 1'b1});
    pop();
    chk("t1_log_empty", 32'(log_empty), 32'd1);
    do_clear();

    // 2: no ack, missed on the 32nd tick of ALARM
    t = now + 8'd6;
    prog(t);
    wait_alarm("t2_alarm", 40);
    seen = 0;
    for (int i = 0; i < 31; i++) begin
      step();
      if (missed === 1'b1) seen = 1;
    end
    chk("t2_no_early_missed", 32'(seen), 32'd0);
    chk("t2_alarm_held", 32'(alarm), 32'd1);
    step();
    chk("t2_missed", 32'(missed), 32'd1);
    chk("t2_alarm_off", 32'(alarm), 32'd0);
    chk("t2_log", {log_empty, log_time, log_idx, log_taken}, {1'b0, t, 4'd0, 1'b0});
    step();
    chk("t2_missed_pulse", 32'(missed), 32'd0);
    pop();
    do_clear();

    // 3: slot1 and slot3 share a time; lowest index first
    t = now + 8'd12;
    prog(t + 8'd100);
    prog(t);
    prog(t + 8'd100);
    prog(t);
    wait_alarm("t3_alarm_a", 40);
    chk("t3_idx_a", 32'(alarm_idx), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t3_alarm_gap", 32'(alarm), 32'd0);
    step();
    chk("t3_alarm_b", 32'(alarm), 32'd1);
    chk("t3_idx_b", 32'(alarm_idx), 32'd3);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t3_log_first", {log_idx, log_taken}, {4'd1, 1'b1});
    pop();
    chk("t3_log_second", {log_time, log_idx}, {t, 4'd3});
    pop();
    chk("t3_log_empty", 32'(log_empty), 32'd1);
    do_clear();

    // 4: five acked doses into a 4-deep log, then read+write while full
    b = now + 8'd20;
    for (int i = 0; i < 5; i++) prog(b + 8'(6 * i));
    for (int i = 0; i < 5; i++) begin
      wait_alarm("t4_alarm", 40);
      ack = 1'b1;
      step();
      ack = 1'b0;
      step();
    end
    chk("t4_full_ovf", {log_full, log_ovf}, 2'b11);
    chk("t4_head", {log_time, log_idx}, {b + 8'd6, 4'd1});
    do_clear();
    chk("t4_clear_ovf", {log_ovf, log_full, slot_count}, {1'b0, 1'b1, 5'd0});
    c = now + 8'd8;
    prog(c);
    wait_alarm("t4_alarm_rw", 40);
    ack = 1'b1;
    log_rd = 1'b1;
    step();
    ack = 1'b0;
    log_rd = 1'b0;
    chk("t4_rw_no_ovf", {log_ovf, log_full}, 2'b01);
    chk("t4_rw_head", {log_time, log_idx}, {b + 8'd12, 4'd2});
    pop();
    pop();
    pop();
    chk("t4_newest", {log_empty, log_time, log_idx, log_taken}, {1'b0, c, 4'd0, 1'b1});
    do_clear();

    // 5: fill slots, 17th ignored, clear mid-alarm keeps log; wrap matches 0
    f = now + 8'd40;
    prog(f);
    for (int i = 0; i < 15; i++) prog(f + 8'd100);
    chk("t5_full", {slot_count, prog_ready}, {5'd16, 1'b0});
    prog(f + 8'd50);
    chk("t5_17th_ignored", 32'(slot_count), 32'd16);
    wait_alarm("t5_alarm", 60);
    chk("t5_idx", 32'(alarm_idx), 32'd0);
    do_clear();
    chk("t5_clear", {alarm, slot_count, prog_ready}, {1'b0, 5'd0, 1'b1});
    chk("t5_log_kept", {log_empty, log_time}, {1'b0, c});
    step();
    step();
    chk("t5_no_realarm", 32'(alarm), 32'd0);
    pop();
    prog(8'd0);
    wait_now("t5_now255", 8'd255);
    chk("t5_alarm_255", 32'(alarm), 32'd0);
    step();
    chk("t5_wrap", 32'(now), 32'd0);
    step();
    chk("t5_alarm_1", 32'(alarm), 32'd0);
    step();
    chk("t5_alarm_wrap", {alarm, now}, {1'b1, 8'd2});
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t5_wrap_log", {log_time, log_taken}, {8'd0, 1'b1});
    pop();
    do_clear();

    // 6: snooze behaviour
    g = now + 8'd8;
    prog(g);
    wait_alarm("t6_alarm", 40);
`ifdef MED_SNOOZE_EN
    for (int i = 0; i < 3; i++) begin
      snooze = 1'b1;
      step();
      snooze = 1'b0;
      chk("t6_snoozed", 32'(alarm), 32'd0);
      wait_alarm("t6_realarm", 20);
    end
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("t6_4th_missed", {missed, alarm}, 2'b10);
    chk("t6_log", {log_time, log_taken}, {g, 1'b0});
`else
    snooze = 1'b1;
    step();
    snooze = 1'b0;
    chk("t6_snooze_ignored", 32'(alarm), 32'd1);
    step();
    step();
    step();
    chk("t6_still_alarm", 32'(alarm), 32'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("t6_ack", {alarm, log_time, log_taken}, {1'b0, g, 1'b1});
`endif
    pop();
    do_clear();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
